ram_writeback_dma: RTL and testbench
====================================

# ram_writeback_dma

Reverse-direction DMA for the matrix datapath: snapshots a DIM×DIM `int` result matrix and writes it element-by-element, row-major, into RAM write port A (`addra`/`dina`/`wea` of `simple_dualport_mem`). RAM port A is arbitrated, so every write is gated by a req/grant handshake. A `done` pulse marks completion. The block sits between the compute stage's matrix output and the shared dual-port RAM, mirroring the ROM→DMA→RAM load path in the opposite direction.

## Interface
- `DATA_WIDTH`, 8, RAM word width; the low `DATA_WIDTH` bits of each `int` element are written.
- `DEPTH`, 16, RAM depth in words.
- `DATA_AMOUNT`, 16, number of elements written per transfer; legal range is 1..DIM*DIM.
- `BASE_ADDR`, 0, RAM address of element [0][0].
- `DIM`, 4, matrix dimension.
- `ADDR_WIDTH` (localparam), $clog2(DEPTH).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: request a transfer; sampled only in IDLE.
- `matrix_data` in int [0:DIM-1][0:DIM-1]: source matrix; captured on the accepted `start` edge.
- `grant` in 1: arbiter grant for RAM port A.
- `req` out 1: request for RAM port A.
- `ram_addr` out ADDR_WIDTH: RAM write address.
- `ram_data` out DATA_WIDTH: RAM write data.
- `ram_wea` out 1: RAM write enable.
- `busy` out 1: high when the block is not in IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE → XFER → DONE → IDLE.
- **IDLE**
  - `req`, `ram_wea`, `busy`, `done` = 0.
  - On `start`=1 at a rising edge: copy all of `matrix_data` into an internal buffer, clear `idx` to 0, go to XFER.
- **XFER**
  - `req`=1 and `busy`=1.
  - `ram_wea` = `grant`, combinational.
  - `ram_addr` = (BASE_ADDR + idx) mod DEPTH; the address wraps modulo DEPTH.
  - `ram_data` = buf[idx / DIM][idx % DIM][DATA_WIDTH-1:0].
  - Each edge where `grant`=1: one write occurs and `idx` increments.
  - When `grant`=1 and idx == DATA_AMOUNT-1: go to DONE.
  - `grant`=0 stalls the transfer: `idx` holds, and `ram_addr`/`ram_data` stay stable.
- **DONE**
  - `done`=1, `busy`=1, `req`=0, `ram_wea`=0 for exactly one cycle, then IDLE.
- **Snapshot:** changes to `matrix_data` after the accepted `start` do not affect the data written.
- **`start` while busy:** ignored; no queueing.
- **`start` in the DONE cycle:** ignored. A new transfer is accepted in the cycle after DONE (IDLE).
- **`grant` outside XFER:** ignored; never produces `ram_wea`.
- **Reset:** all outputs and registers go to 0 (`req`, `ram_wea`, `busy`, `done`, `ram_addr`, `ram_data`, `idx`), the state goes to IDLE, and the buffer is cleared to 0.
  - A reset in mid-transfer aborts the transfer immediately; no further writes occur and no `done` is issued.
- **`ram_addr`/`ram_data` outside XFER:** driven to 0.

## Timing
- **Latency:** `start` is accepted at edge E0, and `req` is high after E0.
  - With `grant` held high, writes commit at edges E1..E(DATA_AMOUNT).
  - `done` is high between E(DATA_AMOUNT) and E(DATA_AMOUNT+1).
  - `busy` falls after E(DATA_AMOUNT+1).
- **Minimum transfer:** DATA_AMOUNT+2 cycles from `start` to the return to IDLE. Each cycle of `grant`=0 during XFER adds one cycle.
- **Handshake:** `grant` may rise in the same cycle `req` rises. There is no combinational path from `grant` to `req`.
- **Write semantics:** the RAM write is taken at the edge where `ram_wea`=1, using the `ram_addr`/`ram_data` values present during that cycle.

## Test plan
1. **Basic transfer:** reset, DATA_AMOUNT=16, BASE_ADDR=0, matrix[r][c]=4r+c+1, `grant` tied to 1, pulse `start` → 16 consecutive writes: addr 0..15, data 0x01..0x10. `done` pulses once, 17 cycles after `start`; `busy` is low after 18 cycles.
2. **Grant stall:** same setup, `grant` alternating 1/0 → exactly 16 writes. No `wea` on cycles where `grant`=0, `ram_addr` held during stalls, `done` 32 cycles after `start`.
3. **Snapshot and truncation:** matrix[0][0]=0x1FF; set all `matrix_data` to 0 one cycle after `start` → first write has data 0xFF (DATA_WIDTH=8); the remaining writes carry the original values.
4. **Address wrap:** BASE_ADDR=14, DATA_AMOUNT=4, DEPTH=16 → writes to addresses 14, 15, 0, 1 with data matrix[0][0..3].
5. **Ignored start:** pulse `start` again mid-XFER and in the DONE cycle → no second transfer and exactly one `done`. A `start` one cycle after DONE begins a new transfer.
6. **Mid-transfer reset:** assert `reset`=0 after 5 writes → `ram_wea`, `req`, `busy` go to 0 immediately without waiting for a clock edge. No `done` is issued. After `reset` is released, a new `start` transfers from idx 0.

Source files
------------

// File: rtl/ram_writeback_dma.sv
// Snapshots a DIM x DIM int matrix on start and writes it row-major into RAM port A, one word per granted cycle.
// Latency: start accepted at E0, writes at E1.., done pulse the cycle after the last write, IDLE one cycle later.
// Backpressure: grant low stalls the transfer with idx, ram_addr and ram_data held; start is ignored unless IDLE.
module ram_writeback_dma #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int DATA_AMOUNT = 16,
  parameter int BASE_ADDR   = 0,
  parameter int DIM         = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  int                    matrix_data [0:DIM-1][0:DIM-1],
  input  logic                  grant,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wea,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;
  localparam int DIM_W = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  int               mat_buf [0:DIM-1][0:DIM-1];
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;

  assign row = DIM_W'(32'(idx) / DIM);
  assign col = DIM_W'(32'(idx) % DIM);

  // Address, data and write enable follow idx directly so a stalled cycle presents the same word.
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wea  = 1'b0;
    if (state == XFER) begin
      ram_addr = ADDR_WIDTH'((BASE_ADDR + 32'(idx)) % DEPTH);
      ram_data = mat_buf[row][col][DATA_WIDTH-1:0];
      ram_wea  = grant;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mat_buf[r][c] <= 0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mat_buf <= matrix_data;
            idx     <= '0;
            req     <= 1'b1;
            busy    <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          if (grant) begin
            if (idx == IDX_W'(DATA_AMOUNT - 1)) begin
              req   <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_writeback_dma.sv
// Bench for ram_writeback_dma: reference write list per transfer, a vector table for address wrap, and random transfers.
module tb_ram_writeback_dma;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int N = 16;
  localparam int DIM = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, grant, start_w, grant_w;
  int   matrix_data [0:DIM-1][0:DIM-1];

  logic          req, ram_wea, busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          req_w, ram_wea_w, busy_w, done_w;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_data_w;

  ram_writeback_dma #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DATA_AMOUNT(N), .BASE_ADDR(0), .DIM(DIM)) dut (
    .clk(clk), .reset(reset), .start(start), .matrix_data(matrix_data), .grant(grant),
    .req(req), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wea(ram_wea), .busy(busy), .done(done));

  ram_writeback_dma #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DATA_AMOUNT(4), .BASE_ADDR(14), .DIM(DIM)) dut_wrap (
    .clk(clk), .reset(reset), .start(start_w), .matrix_data(matrix_data), .grant(grant_w),
    .req(req_w), .ram_addr(ram_addr_w), .ram_data(ram_data_w), .ram_wea(ram_wea_w), .busy(busy_w), .done(done_w));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, ".req"}, 32'(req), 0);
    chk({tag, ".wea"}, 32'(ram_wea), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".addr"}, 32'(ram_addr), 0);
    chk({tag, ".data"}, 32'(ram_data), 0);
  endtask

  task automatic idle_step(input string tag);
    @(negedge clk);
    start = 1'b0;
    grant = 1'($urandom_range(0, 1));
    #1;
    idle_check(tag);
  endtask

  // mode 0: grant held high, 1: alternating 1/0, 2: random.
  // abort_k >= 0 asserts reset in the cycle presenting write number abort_k.
  task automatic xfer(input string tag, input int mode, input bit zero_after, input bit extra_start,
                      input int abort_k, input int exp_done);
    int ea[$];
    int ed[$];
    int k;
    int cyc;
    bit g;
    for (int i = 0; i < N; i++) begin
      ea.push_back(i % DEPTH);
      ed.push_back(matrix_data[i / DIM][i % DIM] & 32'hFF);
    end
    @(negedge clk);
    start = 1'b1;
    grant = 1'($urandom_range(0, 1));
    #1;
    idle_check({tag, ".pre"});
    k = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 3 || k == N);
      if (zero_after && cyc == 1)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            matrix_data[r][c] = 0;
      case (mode)
        0: g = 1'b1;
        1: g = 1'(cyc % 2);
        default: g = 1'($urandom_range(0, 1));
      endcase
      grant = g;
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b0;
        #1;
        chk({tag, ".abort_wea"}, 32'(ram_wea), 0);
        chk({tag, ".abort_req"}, 32'(req), 0);
        chk({tag, ".abort_busy"}, 32'(busy), 0);
        chk({tag, ".abort_done"}, 32'(done), 0);
        return;
      end
      #1;
      if (k < N) begin
        chk({tag, ".req"}, 32'(req), 1);
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".wea"}, 32'(ram_wea), 32'(g));
        chk({tag, ".addr"}, 32'(ram_addr), ea[k]);
        chk({tag, ".data"}, 32'(ram_data), ed[k]);
        if (g) k++;
      end else begin
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".dbusy"}, 32'(busy), 1);
        chk({tag, ".dreq"}, 32'(req), 0);
        chk({tag, ".dwea"}, 32'(ram_wea), 0);
        if (exp_done >= 0) chk({tag, ".done_cycle"}, cyc, exp_done);
        return;
      end
      if (cyc > 200) begin
        chk({tag, ".timeout"}, cyc, 0);
        return;
      end
    end
  endtask

  typedef struct {
    bit st, gr;
    bit req, wea;
    int addr, data;
    bit done, busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0,  0,     0, 0};
    tbl[1] = '{0, 1, 1, 1, 14, 'h1A,  0, 1};
    tbl[2] = '{1, 0, 1, 0, 15, 'h2B,  0, 1};
    tbl[3] = '{0, 1, 1, 1, 15, 'h2B,  0, 1};
    tbl[4] = '{0, 1, 1, 1, 0,  'h3C,  0, 1};
    tbl[5] = '{0, 1, 1, 1, 1,  'h4D,  0, 1};
    tbl[6] = '{1, 1, 0, 0, 0,  0,     1, 1};
    tbl[7] = '{0, 1, 0, 0, 0,  0,     0, 0};

    reset = 1'b0; start = 1'b0; grant = 1'b1; start_w = 1'b0; grant_w = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        matrix_data[r][c] = 0;
    repeat (2) @(negedge clk);
    #1;
    idle_check("reset");
    @(negedge clk);
    reset = 1'b1;

    // Basic transfer
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        matrix_data[r][c] = 4 * r + c + 1;
    xfer("basic", 0, 0, 0, -1, 17);
    idle_step("basic.after");

    // Grant alternating
    xfer("stall", 1, 0, 0, -1, 32);
    idle_step("stall.after");

    // Snapshot and truncation
    matrix_data[0][0] = 'h1FF;
    xfer("snap", 0, 1, 0, -1, 17);
    idle_step("snap.after");

    // Address wrap on the second instance, vector table
    matrix_data[0][0] = 'h1A; matrix_data[0][1] = 'h2B;
    matrix_data[0][2] = 'h3C; matrix_data[0][3] = 'h4D;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_w = tbl[i].st;
      grant_w = tbl[i].gr;
      #1;
      chk($sformatf("wrap[%0d].req", i), 32'(req_w), 32'(tbl[i].req));
      chk($sformatf("wrap[%0d].wea", i), 32'(ram_wea_w), 32'(tbl[i].wea));
      chk($sformatf("wrap[%0d].addr", i), 32'(ram_addr_w), tbl[i].addr);
      chk($sformatf("wrap[%0d].data", i), 32'(ram_data_w), tbl[i].data);
      chk($sformatf("wrap[%0d].done", i), 32'(done_w), 32'(tbl[i].done));
      chk($sformatf("wrap[%0d].busy", i), 32'(busy_w), 32'(tbl[i].busy));
    end
    start_w = 1'b0;

    // Ignored starts, then a start in the cycle right after DONE
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        matrix_data[r][c] = 16 * r + c + 3;
    xfer("ignore", 0, 0, 1, -1, 17);
    xfer("back2back", 0, 0, 0, -1, 17);
    idle_step("back2back.after");

    // Mid-transfer reset after 5 writes
    xfer("abort", 0, 0, 0, 5, -1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("abort.hold_done", 32'(done), 0);
      chk("abort.hold_wea", 32'(ram_wea), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    xfer("restart", 0, 0, 0, -1, 17);
    idle_step("restart.after");

    // Random matrices, random grant, random ignored starts
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          matrix_data[r][c] = int'($urandom);
      xfer($sformatf("rand%0d", t), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
      idle_step($sformatf("rand%0d.after", t));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
